pong_frame_reader: RTL and testbench



---
 rtl/pong_frame_reader.sv | 173 +++++++++++++++++
 tb/tb_pong_frame_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_frame_reader.sv
// rtl/pong_frame_reader.sv - Avalon-MM framebuffer read master with 1bpp pixel stream output
//
// Scans FRAME_WORDS 32-bit words starting at BASE_WORD and streams them
// LSB first as one pixel per handshake, with a FIFO_DEPTH-word buffer
// between the RAM reads and the unpacker.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, abort            frame request / cancel
//   busy, done              frame in progress / one-cycle completion pulse
//   mem_*                   Avalon-MM read master toward the on-chip RAM
//   pix_data, pix_valid,    pixel stream with valid/ready handshake;
//   pix_ready, pix_sof,     sof marks pixel 0, eol marks the last pixel
//   pix_eol                 of each display line

module pong_frame_reader #(
    parameter int BASE_WORD   = 0,
    parameter int FRAME_WORDS = 600,
    parameter int LINE_WORDS  = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [11:0] mem_address,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic        mem_clken,
    input  logic [31:0] mem_readdata,
    output logic        pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int WCNT_W = $clog2(FRAME_WORDS + 1);
    localparam int LCNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t state, state_next;

    logic [WCNT_W-1:0] rd_word;     // reads issued in this frame
    logic              rd_pending;  // a read was issued last cycle; data arrives now
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr, fifo_count;
    logic              fifo_push, fifo_pop, fifo_empty;
    logic [31:0]       u_word;
    logic [4:0]        u_bit;
    logic              u_full;
    logic [WCNT_W-1:0] out_word;    // index of the word in the unpacker
    logic [LCNT_W-1:0] line_word;   // position of that word within its line
    logic              start_accept, pix_hs, word_end, last_hs, credit_ok;

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_count == '0);

    // Credit counts words in the FIFO plus the read whose data lands next
    // edge, so an issued read always has a free slot when it arrives.
    assign credit_ok = (fifo_count + (PTR_W+1)'(rd_pending)) < (PTR_W+1)'(FIFO_DEPTH);

    // The done cycle already shows IDLE, so it is excluded explicitly to
    // keep a start coincident with done from launching a new frame.
    assign start_accept = (state == S_IDLE) && start && !abort && !done;
    assign pix_hs       = u_full && pix_ready;
    assign word_end     = pix_hs && (u_bit == 5'd31);
    assign last_hs      = word_end && (state == S_DRAIN) &&
                          (out_word == WCNT_W'(FRAME_WORDS - 1));

    // Refill on the bit-31 handshake keeps the stream gapless.
    assign fifo_pop  = !fifo_empty && (!u_full || word_end) && !abort;
    assign fifo_push = rd_pending && !abort;

    always_comb begin
        state_next     = state;
        mem_chipselect = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_accept) state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_chipselect = credit_ok && !abort;
                if (mem_chipselect && (rd_word == WCNT_W'(FRAME_WORDS - 1)))
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_hs) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_word    <= '0;
            rd_pending <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            u_word     <= '0;
            u_bit      <= '0;
            u_full     <= 1'b0;
            out_word   <= '0;
            line_word  <= '0;
            done       <= 1'b0;
        end else begin
            done       <= last_hs && !abort;
            rd_pending <= mem_chipselect;

            if (start_accept)        rd_word <= '0;
            else if (mem_chipselect) rd_word <= rd_word + 1'b1;

            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
                if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            end

            if (abort) begin
                u_full <= 1'b0;
            end else if (fifo_pop) begin
                u_word <= fifo_mem[rd_ptr[PTR_W-1:0]];
                u_bit  <= '0;
                u_full <= 1'b1;
            end else if (pix_hs) begin
                if (u_bit == 5'd31) u_full <= 1'b0;
                else                u_bit  <= u_bit + 1'b1;
            end

            if (start_accept) begin
                out_word  <= '0;
                line_word <= '0;
            end else if (word_end) begin
                out_word  <= (out_word == WCNT_W'(FRAME_WORDS - 1)) ? '0 : out_word + 1'b1;
                line_word <= (line_word == LCNT_W'(LINE_WORDS - 1)) ? '0 : line_word + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr[PTR_W-1:0]] <= mem_readdata;
    end

    assign busy        = (state != S_IDLE);
    assign mem_address = 12'(BASE_WORD) + 12'(rd_word);
    assign pix_valid   = u_full;
    assign pix_data    = u_full && u_word[u_bit];
    assign pix_sof     = u_full && (out_word == '0) && (u_bit == 5'd0);
    assign pix_eol     = u_full && (u_bit == 5'd31) &&
                         (line_word == LCNT_W'(LINE_WORDS - 1));

endmodule

// File: tb/tb_pong_frame_reader.sv
// tb/tb_pong_frame_reader.sv - randomized self-checking bench for pong_frame_reader
module tb_pong_frame_reader;

    localparam int BASE_WORD   = 0;
    localparam int FRAME_WORDS = 600;
    localparam int LINE_WORDS  = 5;
    localparam int FIFO_DEPTH  = 4;
    localparam int TOTAL       = FRAME_WORDS * 32;
    localparam int LINE_PIX    = LINE_WORDS * 32;

    logic        clk = 1'b0;
    logic        reset_n, start, abort, pix_ready;
    logic        busy, done, mem_chipselect, mem_write, mem_clken;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        pix_data, pix_valid, pix_sof, pix_eol;

    always #5 clk = ~clk;

    pong_frame_reader #(
        .BASE_WORD(BASE_WORD), .FRAME_WORDS(FRAME_WORDS),
        .LINE_WORDS(LINE_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_val(input int k);
        return (32'(k) * 32'h01010101) ^ 32'hA5A5A5A5;
    endfunction

    function automatic logic ref_pix(input int p);
        logic [31:0] w;
        w = word_val(p / 32);
        return w[p % 32];
    endfunction

    // RAM slave: data for a chipselect cycle is presented during the following cycle.
    logic        prev_cs = 1'b0;
    logic [11:0] prev_addr = '0;
    initial begin
        mem_readdata = '0;
        forever begin
            @(negedge clk);
            if (prev_cs && int'(prev_addr) >= BASE_WORD && int'(prev_addr) < BASE_WORD + FRAME_WORDS)
                mem_readdata = word_val(int'(prev_addr) - BASE_WORD);
            else
                mem_readdata = $urandom;
            prev_cs   = mem_chipselect;
            prev_addr = mem_address;
        end
    end

    // Behavioural frame model: which pixel is next, how many reads issued,
    // whether a frame is active, whether done is owed this cycle.
    int   exp_idx = 0, issued = 0, loaded = 0;
    bit   model_busy = 0, done_due = 0, done_n = 0, hs = 0;
    bit   hold_prev = 0;
    logic hold_data, hold_sof, hold_eol;
    int   sof_cnt = 0, eol_cnt = 0, done_cnt = 0, reads_cnt = 0;
    logic obs_pix [64];

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_cs", 32'(mem_chipselect), 0);
            chk("rst_valid", 32'(pix_valid), 0);
            chk("rst_outs", {29'd0, pix_data, pix_sof, pix_eol}, 0);
            model_busy = 0; done_due = 0; exp_idx = 0; issued = 0; hold_prev = 0;
        end else begin
            chk("done", 32'(done), 32'(done_due));
            chk("busy", 32'(busy), 32'(model_busy));
            if (done) done_cnt++;
            if (!model_busy) begin
                chk("valid_idle", 32'(pix_valid), 0);
                chk("cs_idle", 32'(mem_chipselect), 0);
            end
            if (hold_prev) begin
                chk("hold_valid", 32'(pix_valid), 1);
                chk("hold_data", 32'(pix_data), 32'(hold_data));
                chk("hold_sof", 32'(pix_sof), 32'(hold_sof));
                chk("hold_eol", 32'(pix_eol), 32'(hold_eol));
            end
            if (pix_valid && model_busy) begin
                if (exp_idx < TOTAL) begin
                    chk("pix_data", 32'(pix_data), 32'(ref_pix(exp_idx)));
                    chk("pix_sof", 32'(pix_sof), 32'(exp_idx == 0));
                    chk("pix_eol", 32'(pix_eol), 32'((exp_idx % LINE_PIX) == LINE_PIX - 1));
                end else begin
                    chk("pix_overrun", exp_idx, TOTAL - 1);
                end
            end
            if (mem_chipselect) begin
                loaded = exp_idx / 32 + (pix_valid ? 1 : 0);
                chk("rd_addr", 32'(mem_address), 32'(BASE_WORD + issued));
                chk("rd_credit_exceeded", 32'((issued - loaded) >= FIFO_DEPTH), 0);
                chk("rd_past_frame", 32'(issued >= FRAME_WORDS), 0);
                issued++;
                reads_cnt++;
            end
            hs        = pix_valid && pix_ready;
            hold_prev = pix_valid && !pix_ready && !abort;
            hold_data = pix_data; hold_sof = pix_sof; hold_eol = pix_eol;
            done_n    = hs && (exp_idx == TOTAL - 1) && !abort;
            if (hs) begin
                if (exp_idx < 64) obs_pix[exp_idx] = pix_data;
                if (pix_sof) sof_cnt++;
                if (pix_eol) eol_cnt++;
                exp_idx++;
            end
            if (abort)       model_busy = 0;
            else if (done_n) model_busy = 0;
            else if (!model_busy && !done_due && start) begin
                model_busy = 1; exp_idx = 0; issued = 0;
            end
            done_due = done_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n, first, sr, reads_a;
    bit got;

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
        repeat (3) tick();
        chk("tie_write", 32'(mem_write), 0);
        chk("tie_be", 32'(mem_byteenable), 32'hF);
        chk("tie_clken", 32'(mem_clken), 1);
        chk("rst_addr", 32'(mem_address), 0);
        reset_n = 1'b1;
        tick();

        // reset asserted mid-frame
        pix_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
        repeat (500) tick();
        chk("midframe_busy", 32'(busy), 1);
        reset_n = 1'b0; #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_valid", 32'(pix_valid), 0);
        tick(); tick();
        reset_n = 1'b1;
        reads_cnt = 0;
        repeat (20) tick();
        chk("no_reads_after_reset", reads_cnt, 0);
        chk("idle_after_reset", 32'(busy), 0);

        // full frame, ready high, start during FETCH and at done
        sof_cnt = 0; eol_cnt = 0; done_cnt = 0; reads_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0; first = -1; got = 0;
        while (n < 25000 && !got) begin
            tick(); n++;
            start = (n == 50);
            if (first < 0 && pix_valid) first = n;
            if (done) begin got = 1; start = 1'b1; end
        end
        reads_a = reads_cnt;
        if (got) begin tick(); start = 1'b0; end
        chk("frameA_done_seen", 32'(got), 1);
        chk("frameA_done_latency", n, 19203);
        chk("frameA_first_valid", first, 3);
        chk("frameA_reads", reads_a, FRAME_WORDS);
        chk("frameA_pix0", 32'(obs_pix[0]), 1);
        chk("frameA_pix1", 32'(obs_pix[1]), 0);
        chk("frameA_pix2", 32'(obs_pix[2]), 1);
        chk("frameA_pix32", 32'(obs_pix[32]), 0);
        chk("frameA_pix34", 32'(obs_pix[34]), 1);
        reads_cnt = 0;
        repeat (10) tick();
        chk("start_at_done_busy", 32'(busy), 0);
        chk("start_at_done_reads", reads_cnt, 0);
        chk("frameA_sof_cnt", sof_cnt, 1);
        chk("frameA_eol_cnt", eol_cnt, TOTAL / LINE_PIX);
        chk("frameA_done_cnt", done_cnt, 1);

        // random ready frame with a 200-cycle stall
        sof_cnt = 0; eol_cnt = 0; done_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0; got = 0;
        while (n < 60000 && !got) begin
            if (n == 3000) begin
                pix_ready = 1'b0; sr = 0;
                repeat (200) begin
                    if (mem_chipselect) sr++;
                    tick(); n++;
                end
                chk("stall_reads", 32'(sr > FIFO_DEPTH), 0);
                chk("stall_valid", 32'(pix_valid), 1);
            end
            pix_ready = 1'($urandom_range(1, 0));
            tick(); n++;
            if (done) got = 1;
        end
        pix_ready = 1'b1;
        chk("frameB_done_seen", 32'(got), 1);
        tick();
        chk("frameB_sof_cnt", sof_cnt, 1);
        chk("frameB_eol_cnt", eol_cnt, TOTAL / LINE_PIX);
        chk("frameB_done_cnt", done_cnt, 1);

        // abort near pixel 1000 with a read in flight
        done_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (n < 5000 && !(exp_idx >= 1000 && mem_chipselect)) begin tick(); n++; end
        chk("abort_point_reached", 32'(n < 5000), 1);
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(pix_valid), 0);
        repeat (40) tick();
        chk("abort_no_done", done_cnt, 0);

        start = 1'b1; tick(); start = 1'b0;
        n = 0; first = -1;
        while (n < 20 && first < 0) begin
            tick(); n++;
            if (pix_valid) first = n;
        end
        chk("restart_first_valid", first, 3);
        chk("restart_sof", 32'(pix_sof), 1);
        chk("restart_pix0", 32'(pix_data), 1);
        repeat (3000) begin
            pix_ready = 1'($urandom_range(1, 0));
            tick();
        end
        abort = 1'b1; tick(); abort = 1'b0;
        pix_ready = 1'b1;
        repeat (20) tick();
        chk("abort2_busy", 32'(busy), 0);
        chk("abort2_no_done", done_cnt, 0);

        // start plus abort while idle
        reads_cnt = 0;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        repeat (5) tick();
        chk("start_abort_idle_busy", 32'(busy), 0);
        chk("start_abort_idle_reads", reads_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
